// File: rtl/io_uart_tx_if.sv
// -----------------------------------------------------------------------------
// io_uart_tx_if
// Core 8-bit IO bus as seen by a responder such as io_uart_tx.
//   io_addr        8   IO word address (byte address, [1:0] ignored)
//   io_en          1   access strobe, one cycle per access
//   io_we          1   1=write, 0=read (qualified by io_en)
//   io_data_write  32  write data
//   io_data_read   32  read data from the responder, 0 when not selected
// master: the core driving accesses; slave: the responding peripheral.
// -----------------------------------------------------------------------------
interface io_uart_tx_if;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;

    modport master (
        output io_addr, io_en, io_we, io_data_write,
        input  io_data_read
    );

    modport slave (
        input  io_addr, io_en, io_we, io_data_write,
        output io_data_read
    );
endinterface

// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
// Memory-mapped UART transmitter on the core IO bus. Bytes written to TXDATA
// are queued in a TX FIFO and sent as 8N1 frames (start, 8 data LSB first,
// stop), each bit lasting DIVISOR clock cycles.
//   clk       clock, all state on the rising edge
//   reset     asynchronous, active-high
//   io        IO bus, slave side (addr/en/we/write data in, read data out)
//   uart_txd  serial output, idle high, driven straight from a flop
//   irq_tx    TX-done interrupt
// Register map at io_addr[3:2] when io_addr[7:4] == BASE_ADDR[7:4]:
//   0 TXDATA  W push [7:0]; R 0
//   1 STATUS  R [0]busy [1]full [2]empty [3]ovf [15:8]count; W bit3=1 clears ovf
//   2 DIVISOR R/W [DIV_WIDTH-1:0]; writing 0 stores 1
//   3 IRQEN   R/W [0] irq_en
// Optional feature macro IO_UART_TX_IRQ_EN: when defined, IRQEN exists and
// irq_tx = registered (irq_en & fifo empty & ~busy). When undefined, IRQEN
// reads 0, writes are ignored and irq_tx is tied low.
// -----------------------------------------------------------------------------
module io_uart_tx #(
    parameter logic [7:0]  BASE_ADDR  = 8'h20,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DIV_RESET  = 434
) (
    input  logic         clk,
    input  logic         reset,
    io_uart_tx_if.slave  io,
    output logic         uart_txd,
    output logic         irq_tx
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 txd_q, txd_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 sel, wr, push, pop, busy, fifo_empty, fifo_full, bit_end;
    logic [1:0]           reg_idx;
    logic [DIV_WIDTH-1:0] reload, wdiv;
    logic [31:0]          rdata;
    logic                 unused_bus;

    assign sel        = io.io_en && (io.io_addr[7:4] == BASE_ADDR[7:4]);
    assign wr         = sel && io.io_we;
    assign reg_idx    = io.io_addr[3:2];
    assign busy       = (state_q != S_IDLE);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign bit_end    = (cnt_q == '0);
    assign reload     = div_q - DIV_WIDTH'(1);
    assign wdiv       = io.io_data_write[DIV_WIDTH-1:0];
    assign unused_bus = ^{io.io_data_write, io.io_addr[1:0]};

    // Transmit FSM, FIFO and register writes
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        txd_d     = txd_q;
        div_d     = div_q;
        ovf_d     = ovf_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop       = 1'b0;
        push      = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = reload;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    cnt_d     = reload;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit: no idle gap
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        cnt_d   = reload;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        if (wr && reg_idx == 2'd0) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   ovf_d = 1'b1;
        end
        if (wr && reg_idx == 2'd1 && io.io_data_write[3]) ovf_d = 1'b0;
        if (wr && reg_idx == 2'd2) div_d = (wdiv == '0) ? DIV_WIDTH'(1) : wdiv;

        if (push) begin
            mem_d[wr_ptr_q] = io.io_data_write[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            txd_q     <= 1'b1;
            div_q     <= DIV_WIDTH'(DIV_RESET);
            ovf_q     <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            txd_q     <= txd_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign uart_txd = txd_q;

`ifdef IO_UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && reg_idx == 2'd3) irq_en_d = io.io_data_write[0];
        irq_d = irq_en_q && fifo_empty && !busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_tx = irq_q;
`else
    assign irq_tx = 1'b0;
`endif

    // Read mux: purely combinational, no side effects
    always_comb begin
        rdata = '0;
        if (sel && !io.io_we) begin
            case (reg_idx)
                2'd1:    rdata = {16'h0, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, busy};
                2'd2:    rdata = 32'(div_q);
`ifdef IO_UART_TX_IRQ_EN
                2'd3:    rdata = {31'h0, irq_en_q};
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign io.io_data_read = rdata;
endmodule
